uart_hex_parser: RTL and testbench
==================================

# uart_hex_parser

Converts the byte stream from the UART receiver into binary values by parsing pairs of ASCII hex characters. It sits directly downstream of `UART_RX`, taking its `o_RX_DV`/`o_RX_Byte` strobe pair. It presents each parsed byte on a held output with a one-cycle valid strobe for the seven-segment display path or other consumers. Invalid characters and abandoned half-entries raise an error strobe and a sticky error flag.

## Interface
- `TIMEOUT_CLKS`, default 25000000: cycles allowed between first and second hex digit before the half-entry is discarded (1 s at 25 MHz); 0 disables the timeout.
- `CLK`  in  1  system clock (same clock as `UART_RX`).
- `RST`  in  1  reset; synchronous, active-high.
- `i_RX_DV`  in  1  received-byte strobe; each high cycle carries one byte.
- `i_RX_Byte`  in  8  received ASCII byte, valid when `i_RX_DV`=1.
- `o_Byte`  out  8  last parsed value, held until the next emission.
- `o_Byte_DV`  out  1  one-cycle strobe when `o_Byte` updates.
- `o_Busy`  out  1  high while one digit is held (state `HAVE_HI`).
- `o_Err`  out  1  one-cycle error strobe.
- `o_Err_Sticky`  out  1  set by any `o_Err`; cleared only by `RST`.

## Operation
- **Character classes:**
  - hex: 0x30–0x39 → 0–9; 0x41–0x46 and 0x61–0x66 → A–F.
  - terminator: 0x0D (CR), 0x0A (LF), 0x20 (space).
  - all other bytes are invalid.
- **States:** `IDLE`, `HAVE_HI`. A 4-bit register `hi` holds the first digit.
- **`IDLE` transitions:**
  - hex: `hi` ← digit; go to `HAVE_HI`; clear the timeout counter.
  - terminator: ignored, no error.
  - invalid: pulse `o_Err`; stay in `IDLE`.
- **`HAVE_HI` transitions:**
  - hex: `o_Byte` ← {`hi`, digit}; pulse `o_Byte_DV`; go to `IDLE`.
  - terminator: `o_Byte` ← {4'h0, `hi`}; pulse `o_Byte_DV`; go to `IDLE`.
  - invalid: discard `hi`; pulse `o_Err`; go to `IDLE`.
  - timeout expiry with no `i_RX_DV` that cycle: discard `hi`; pulse `o_Err`; go to `IDLE`.
- **Timeout counter:**
  - Width is ceil(log2(`TIMEOUT_CLKS`+1)).
  - Cleared on entry to `HAVE_HI`; increments each `HAVE_HI` cycle without `i_RX_DV`.
  - Expiry is the cycle the counter equals `TIMEOUT_CLKS`-1.
  - Idle in `IDLE`. No wrap occurs, because expiry exits the state.
- **Simultaneous events:** `i_RX_DV` in the expiry cycle is processed as a normal `HAVE_HI` input, and the timeout is suppressed.
- **Mutual exclusion:** `o_Byte_DV` and `o_Err` are never high in the same cycle.
- **Reset:** `RST` has priority over all inputs. `i_RX_DV` in a reset cycle is dropped.
- **Outputs after reset:**
  - `o_Byte`=0x00
  - `o_Byte_DV`=0
  - `o_Busy`=0
  - `o_Err`=0
  - `o_Err_Sticky`=0
  - state `IDLE`, `hi`=0, counter=0

## Timing
- All outputs are registered.
- Latency: the `i_RX_DV` cycle t produces `o_Byte_DV`/`o_Err`/state change visible at t+1.
- `o_Busy` rises at t+1 after a first-digit strobe at t. It falls in the same cycle `o_Byte_DV` or `o_Err` is high.
- Back-to-back `i_RX_DV` on consecutive cycles is fully supported, with no input stall. The block has no backpressure; the consumer must accept every `o_Byte_DV`.
- Timeout: a first digit at cycle t produces `o_Err` at t+`TIMEOUT_CLKS`+1, if no further `i_RX_DV` arrives.
- `o_Byte` changes only in cycles where `o_Byte_DV`=1.
- A `RST` asserted in cycle r gives reset values at r+1, including mid-`HAVE_HI`; the held digit is lost and no error is flagged.

## Test plan
Use `TIMEOUT_CLKS`=16 throughout.

- Strobes 0x34 ('4'), 0x32 ('2') one cycle apart → `o_Byte`=0x42 and `o_Byte_DV`=1 exactly one cycle after the second strobe; `o_Busy` high for one cycle between.
- Strobes 'a' (0x61), 'F' (0x46) back-to-back, then '0','0' → `o_Byte`=0xAF, then 0x00; two DV pulses; `o_Err_Sticky`=0.
- '7' then CR (0x0D) → `o_Byte`=0x07. Separately, CR/LF/space in `IDLE` → no DV, no error.
- 'G' (0x47) in `IDLE` → `o_Err` one-cycle pulse, `o_Err_Sticky`=1, `o_Byte` unchanged. Then '1','Z' → error, `o_Busy`=0, no DV.
- Timeout cases:
  - '5' at cycle t, nothing after → `o_Err` at t+17, state `IDLE`.
  - Repeat with '9' strobed exactly in the expiry cycle → `o_Byte`=0x59, no error.
- '3' then `RST` for one cycle, then 'C','D' → all outputs at reset values after `RST`, then `o_Byte`=0xCD; no stale 0x3_ value and `o_Err_Sticky`=0.

Source files
------------

// File: rtl/uart_hex_parser.sv
// Parses pairs of ASCII hex characters from the UART receiver into bytes.
// A lone digit followed by a terminator is zero-extended; bad input and stale half-entries raise errors.
module uart_hex_parser #(
  parameter int unsigned TIMEOUT_CLKS = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Byte,
  output logic       o_Byte_DV,
  output logic       o_Busy,
  output logic       o_Err,
  output logic       o_Err_Sticky
);

  localparam int unsigned CNT_W   = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam int unsigned EXP_INT = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0;
  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_INT);
  localparam bit TIMEOUT_EN = (TIMEOUT_CLKS != 0);

  typedef enum logic {IDLE, HAVE_HI} state_t;

  function automatic logic is_dec(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_alpha(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h46)) || ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A) || (b == 8'h20);
  endfunction

  // Letters: low nibble of 'A'/'a' is 1, so adding 9 maps A..F to 10..15.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return is_dec(b) ? b[3:0] : (b[3:0] + 4'd9);
  endfunction

  state_t           r_state;
  logic [3:0]       r_hi;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_byte;
  logic             r_byte_dv;
  logic             r_err;
  logic             r_err_sticky;

  logic       w_is_hex;
  logic       w_is_term;
  logic [3:0] w_digit;
  logic       w_expire;

  always_comb begin
    w_is_hex  = is_dec(i_RX_Byte) || is_alpha(i_RX_Byte);
    w_is_term = is_term(i_RX_Byte);
    w_digit   = hex_val(i_RX_Byte);
    w_expire  = TIMEOUT_EN && (r_state == HAVE_HI) && !i_RX_DV && (r_cnt == EXP_CNT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_hi         <= 4'h0;
      r_cnt        <= '0;
      r_byte       <= 8'h00;
      r_byte_dv    <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_byte_dv <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_RX_DV) begin
            if (w_is_hex) begin
              r_hi    <= w_digit;
              r_cnt   <= '0;
              r_state <= HAVE_HI;
            end else if (!w_is_term) begin
              r_err        <= 1'b1;
              r_err_sticky <= 1'b1;
            end
          end
        end
        HAVE_HI: begin
          // A strobe in the expiry cycle wins over the timeout.
          if (i_RX_DV) begin
            if (w_is_hex) begin
              r_byte    <= {r_hi, w_digit};
              r_byte_dv <= 1'b1;
            end else if (w_is_term) begin
              r_byte    <= {4'h0, r_hi};
              r_byte_dv <= 1'b1;
            end else begin
              r_err        <= 1'b1;
              r_err_sticky <= 1'b1;
            end
            r_hi    <= 4'h0;
            r_state <= IDLE;
          end else if (w_expire) begin
            r_err        <= 1'b1;
            r_err_sticky <= 1'b1;
            r_hi         <= 4'h0;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_Byte       = r_byte;
  assign o_Byte_DV    = r_byte_dv;
  assign o_Busy       = (r_state == HAVE_HI);
  assign o_Err        = r_err;
  assign o_Err_Sticky = r_err_sticky;

endmodule

// File: tb/tb_uart_hex_parser.sv
// Directed bench for uart_hex_parser with TIMEOUT_CLKS=16.
module tb_uart_hex_parser;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00;
  logic [7:0] o_Byte;
  logic       o_Byte_DV;
  logic       o_Busy;
  logic       o_Err;
  logic       o_Err_Sticky;

  int checks = 0;
  int failures = 0;

  uart_hex_parser #(.TIMEOUT_CLKS(16)) dut (
    .CLK(CLK), .RST(RST), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .o_Byte(o_Byte), .o_Byte_DV(o_Byte_DV), .o_Busy(o_Busy),
    .o_Err(o_Err), .o_Err_Sticky(o_Err_Sticky)
  );

  always #5 CLK = ~CLK;

  // Apply inputs for the current cycle, then land 1 time unit after the edge.
  task automatic drive(input logic dv, input logic [7:0] b);
    i_RX_DV   = dv;
    i_RX_Byte = b;
    @(posedge CLK);
    #1;
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h34);
    RST = 1'b0;
    checks++; if (o_Byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", o_Byte); end
    checks++; if (o_Byte_DV !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", o_Byte_DV); end
    checks++; if (o_Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_Busy); end
    checks++; if (o_Err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", o_Err); end
    checks++; if (o_Err_Sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b exp=0", o_Err_Sticky); end
  endtask

  task automatic test_pair();
    drive(1'b1, 8'h34);
    checks++; if (o_Busy !== 1'b1 || o_Byte_DV !== 1'b0) begin failures++; $display("FAIL pair_busy got busy=%b dv=%b exp busy=1 dv=0", o_Busy, o_Byte_DV); end
    drive(1'b1, 8'h32);
    checks++; if (o_Byte_DV !== 1'b1 || o_Byte !== 8'h42) begin failures++; $display("FAIL pair_out got dv=%b byte=%h exp dv=1 byte=42", o_Byte_DV, o_Byte); end
    checks++; if (o_Busy !== 1'b0) begin failures++; $display("FAIL pair_busy_fall got=%b exp=0", o_Busy); end
    drive(1'b0, 8'h00);
    checks++; if (o_Byte_DV !== 1'b0 || o_Byte !== 8'h42) begin failures++; $display("FAIL pair_hold got dv=%b byte=%h exp dv=0 byte=42", o_Byte_DV, o_Byte); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    int pulses;
    seq[0] = 8'h61; seq[1] = 8'h46; seq[2] = 8'h30; seq[3] = 8'h30;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i]);
      if (o_Byte_DV === 1'b1) pulses++;
      if (i == 1) begin
        checks++; if (o_Byte_DV !== 1'b1 || o_Byte !== 8'hAF) begin failures++; $display("FAIL b2b_af got dv=%b byte=%h exp dv=1 byte=af", o_Byte_DV, o_Byte); end
      end
      if (i == 3) begin
        checks++; if (o_Byte_DV !== 1'b1 || o_Byte !== 8'h00) begin failures++; $display("FAIL b2b_00 got dv=%b byte=%h exp dv=1 byte=00", o_Byte_DV, o_Byte); end
      end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    checks++; if (o_Err_Sticky !== 1'b0) begin failures++; $display("FAIL b2b_sticky got=%b exp=0", o_Err_Sticky); end
  endtask

  task automatic test_term();
    logic [7:0] terms [3];
    terms[0] = 8'h0D; terms[1] = 8'h0A; terms[2] = 8'h20;
    drive(1'b1, 8'h37);
    drive(1'b1, 8'h0D);
    checks++; if (o_Byte_DV !== 1'b1 || o_Byte !== 8'h07) begin failures++; $display("FAIL term_07 got dv=%b byte=%h exp dv=1 byte=07", o_Byte_DV, o_Byte); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, terms[i]);
      checks++; if (o_Byte_DV !== 1'b0 || o_Err !== 1'b0 || o_Busy !== 1'b0) begin failures++; $display("FAIL term_idle_%0d got dv=%b err=%b busy=%b exp all 0", i, o_Byte_DV, o_Err, o_Busy); end
    end
  endtask

  task automatic test_invalid();
    drive(1'b1, 8'h47);
    checks++; if (o_Err !== 1'b1 || o_Err_Sticky !== 1'b1) begin failures++; $display("FAIL inv_g got err=%b sticky=%b exp 1 1", o_Err, o_Err_Sticky); end
    checks++; if (o_Byte !== 8'h07 || o_Byte_DV !== 1'b0) begin failures++; $display("FAIL inv_g_byte got byte=%h dv=%b exp byte=07 dv=0", o_Byte, o_Byte_DV); end
    drive(1'b0, 8'h00);
    checks++; if (o_Err !== 1'b0 || o_Err_Sticky !== 1'b1) begin failures++; $display("FAIL inv_pulse got err=%b sticky=%b exp 0 1", o_Err, o_Err_Sticky); end
    drive(1'b1, 8'h31);
    checks++; if (o_Busy !== 1'b1) begin failures++; $display("FAIL inv_1_busy got=%b exp=1", o_Busy); end
    drive(1'b1, 8'h5A);
    checks++; if (o_Err !== 1'b1 || o_Busy !== 1'b0 || o_Byte_DV !== 1'b0) begin failures++; $display("FAIL inv_z got err=%b busy=%b dv=%b exp 1 0 0", o_Err, o_Busy, o_Byte_DV); end
  endtask

  task automatic test_timeout();
    // '5' strobed in cycle t; we are now in cycle t+1 and observe outputs of t+k after k drives.
    drive(1'b1, 8'h35);
    for (int k = 2; k <= 17; k++) begin
      drive(1'b0, 8'h00);
      if (k < 17) begin
        checks++; if (o_Err !== 1'b0 || o_Busy !== 1'b1) begin failures++; $display("FAIL tmo_wait_%0d got err=%b busy=%b exp 0 1", k, o_Err, o_Busy); end
      end else begin
        checks++; if (o_Err !== 1'b1 || o_Busy !== 1'b0 || o_Byte_DV !== 1'b0) begin failures++; $display("FAIL tmo_expire got err=%b busy=%b dv=%b exp 1 0 0", o_Err, o_Busy, o_Byte_DV); end
      end
    end
    drive(1'b0, 8'h00);
    checks++; if (o_Err !== 1'b0) begin failures++; $display("FAIL tmo_after got err=%b exp=0", o_Err); end
  endtask

  task automatic test_expiry_dv();
    drive(1'b1, 8'h35);
    for (int k = 0; k < 15; k++) drive(1'b0, 8'h00);
    checks++; if (o_Busy !== 1'b1 || o_Err !== 1'b0) begin failures++; $display("FAIL exp_pre got busy=%b err=%b exp 1 0", o_Busy, o_Err); end
    drive(1'b1, 8'h39);
    checks++; if (o_Byte_DV !== 1'b1 || o_Byte !== 8'h59 || o_Err !== 1'b0) begin failures++; $display("FAIL exp_dv got dv=%b byte=%h err=%b exp 1 59 0", o_Byte_DV, o_Byte, o_Err); end
    drive(1'b0, 8'h00);
    checks++; if (o_Err !== 1'b0 || o_Busy !== 1'b0) begin failures++; $display("FAIL exp_after got err=%b busy=%b exp 0 0", o_Err, o_Busy); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h33);
    checks++; if (o_Busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", o_Busy); end
    RST = 1'b1;
    drive(1'b1, 8'h34);
    RST = 1'b0;
    checks++; if (o_Byte !== 8'h00 || o_Busy !== 1'b0 || o_Byte_DV !== 1'b0 || o_Err !== 1'b0 || o_Err_Sticky !== 1'b0) begin
      failures++; $display("FAIL rst_mid_vals got byte=%h busy=%b dv=%b err=%b sticky=%b exp 00 0 0 0 0", o_Byte, o_Busy, o_Byte_DV, o_Err, o_Err_Sticky);
    end
    drive(1'b1, 8'h43);
    checks++; if (o_Busy !== 1'b1 || o_Byte_DV !== 1'b0) begin failures++; $display("FAIL rst_mid_c got busy=%b dv=%b exp 1 0", o_Busy, o_Byte_DV); end
    drive(1'b1, 8'h44);
    checks++; if (o_Byte_DV !== 1'b1 || o_Byte !== 8'hCD || o_Err_Sticky !== 1'b0) begin failures++; $display("FAIL rst_mid_cd got dv=%b byte=%h sticky=%b exp 1 cd 0", o_Byte_DV, o_Byte, o_Err_Sticky); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_back_to_back();
    test_term();
    test_invalid();
    test_timeout();
    test_expiry_dv();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
